inv_butterfly: RTL and testbench

- Radix-2 inverse butterfly for the IFFT path and for round-trip checks against the forward butterfly.
- Takes a forward butterfly output pair (c, d) and twiddle w. Recovers a = (c+d)/2 and b = ((c-d)/2)·conj(w).
- All values are complex, signed fixed point.
- Uses one shared real multiplier over an iterative 4-step schedule, with val/rdy handshakes on both sides.

---
 rtl/inv_butterfly.sv | 158 +++++++++++++++
 tb/tb_inv_butterfly.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_butterfly.sv
// Radix-2 inverse butterfly: a = (c+d)/2, b = ((c-d)/2)*conj(w).
// The general-twiddle build (mult=0) time-shares one real multiplier over
// four cycles. The other mult values hard-wire a trivial twiddle and finish
// on the load edge.
// Optional macro BFLY_INV_ROUND_EN: round half-up on the halving and on the
// product rescale. Without it, both shifts truncate toward -inf.
module inv_butterfly #(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int mult = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] cr,
    input  logic [n-1:0] cc,
    input  logic [n-1:0] dr,
    input  logic [n-1:0] dc,
    input  logic [n-1:0] wr,
    input  logic [n-1:0] wc,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] ar,
    output logic [n-1:0] ac,
    output logic [n-1:0] br,
    output logic [n-1:0] bc
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t state, state_nxt;
    logic [1:0] k;
    logic load;

    logic signed [n-1:0] xr, xi, wr_q, wc_q;
    logic signed [n-1:0] ar_q, ac_q, br_q, bc_q;
    logic signed [n-1:0] half_ar, half_ac, half_xr, half_xi;
    logic signed [n-1:0] fixed_br, fixed_bc;
    logic signed [n-1:0] mul_a, mul_b, term;
    logic signed [2*n-1:0] prod;

    // Halve an (n+1)-bit sum back into n bits. The rounding offset is added in
    // a wider word, so a full-scale sum cannot overflow.
    function automatic logic signed [n-1:0] halve(input logic signed [n:0] s);
`ifdef BFLY_INV_ROUND_EN
        logic signed [n+1:0] t;
        t = (n+2)'(s) + (n+2)'(1);
        return n'(t >>> 1);
`else
        return n'(s >>> 1);
`endif
    endfunction

    // Rescale a 2n-bit product by 2^-d and keep the low n bits.
    function automatic logic signed [n-1:0] scale(input logic signed [2*n-1:0] p);
`ifdef BFLY_INV_ROUND_EN
        logic signed [2*n:0] t;
        t = (2*n+1)'(p) + ((2*n+1)'(1) <<< (d-1));
        return n'(t >>> d);
`else
        return n'(p >>> d);
`endif
    endfunction

    assign recv_rdy = (state == IDLE);
    assign send_val = (state == DONE);
    assign load     = recv_val & recv_rdy;
    assign ar = ar_q;
    assign ac = ac_q;
    assign br = br_q;
    assign bc = bc_q;

    // Half-sums and half-differences of the incoming pair, plus the trivial-twiddle b.
    always_comb begin
        half_ar = halve((n+1)'(signed'(cr)) + (n+1)'(signed'(dr)));
        half_ac = halve((n+1)'(signed'(cc)) + (n+1)'(signed'(dc)));
        half_xr = halve((n+1)'(signed'(cr)) - (n+1)'(signed'(dr)));
        half_xi = halve((n+1)'(signed'(cc)) - (n+1)'(signed'(dc)));
        fixed_br = half_xr;
        fixed_bc = half_xi;
        case (mult)
            2:       begin fixed_br = -half_xr; fixed_bc = -half_xi; end
            3:       begin fixed_br = half_xi;  fixed_bc = -half_xr; end
            4:       begin fixed_br = -half_xi; fixed_bc = half_xr;  end
            default: begin fixed_br = half_xr;  fixed_bc = half_xi;  end
        endcase
    end

    // Operand select for the shared multiplier, one partial product per step.
    always_comb begin
        mul_a = xr;
        mul_b = wr_q;
        case (k)
            2'd0:    begin mul_a = xr; mul_b = wr_q; end
            2'd1:    begin mul_a = xi; mul_b = wc_q; end
            2'd2:    begin mul_a = xi; mul_b = wr_q; end
            default: begin mul_a = xr; mul_b = wc_q; end
        endcase
        prod = (2*n)'(mul_a) * (2*n)'(mul_b);
        term = scale(prod);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: load, then multiply for four steps (general w only), then hold until sent.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (recv_val) state_nxt = (mult == 0) ? MUL : DONE;
            MUL:     if (k == 2'd3) state_nxt = DONE;
            DONE:    if (send_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on load, then accumulate conj-twiddle products into b.
    always_ff @(posedge clk) begin
        if (reset) begin
            k    <= 2'd0;
            xr   <= '0;
            xi   <= '0;
            wr_q <= '0;
            wc_q <= '0;
            ar_q <= '0;
            ac_q <= '0;
            br_q <= '0;
            bc_q <= '0;
        end else if (load) begin
            k    <= 2'd0;
            xr   <= half_xr;
            xi   <= half_xi;
            wr_q <= signed'(wr);
            wc_q <= signed'(wc);
            ar_q <= half_ar;
            ac_q <= half_ac;
            if (mult == 0) begin
                br_q <= '0;
                bc_q <= '0;
            end else begin
                br_q <= fixed_br;
                bc_q <= fixed_bc;
            end
        end else if (state == MUL) begin
            k <= k + 2'd1;
            case (k)
                2'd0, 2'd1: br_q <= br_q + term;
                2'd2:       bc_q <= bc_q + term;
                default:    bc_q <= bc_q - term;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_butterfly.sv
// Bench for inv_butterfly: one instance per twiddle mode (mult = 0..4), all
// sharing the data inputs. A complex-arithmetic reference model supplies the
// expected values.
module tb_inv_butterfly;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rv, sr, rr, sv;
    logic [31:0] tcr, tcc, tdr, tdc, twr, twc;
    logic [31:0] ar_o [5];
    logic [31:0] ac_o [5];
    logic [31:0] br_o [5];
    logic [31:0] bc_o [5];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        inv_butterfly #(.n(32), .d(16), .mult(g)) u_bfly (
            .clk(clk), .reset(reset),
            .recv_val(rv[g]), .recv_rdy(rr[g]),
            .cr(tcr), .cc(tcc), .dr(tdr), .dc(tdc), .wr(twr), .wc(twc),
            .send_val(sv[g]), .send_rdy(sr[g]),
            .ar(ar_o[g]), .ac(ac_o[g]), .br(br_o[g]), .bc(bc_o[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [31:0] v);
        return longint'(signed'(v));
    endfunction

    function automatic longint half(input longint s);
`ifdef BFLY_INV_ROUND_EN
        return sx(32'((s + 1) >>> 1));
`else
        return sx(32'(s >>> 1));
`endif
    endfunction

    function automatic longint scl(input longint p);
`ifdef BFLY_INV_ROUND_EN
        return sx(32'((p + 64'sd32768) >>> 16));
`else
        return sx(32'(p >>> 16));
`endif
    endfunction

    // a = (c+d)/2; b = x * conj(w), x = (c-d)/2.
    function automatic void model(input int g, input logic [31:0] icr, icc, idr, idc, iwr, iwc,
                                  output logic [31:0] ear, eac, ebr, ebc);
        longint xr, xi, cwr, cwi;
        ear = 32'(half(sx(icr) + sx(idr)));
        eac = 32'(half(sx(icc) + sx(idc)));
        xr  = half(sx(icr) - sx(idr));
        xi  = half(sx(icc) - sx(idc));
        if (g == 0) begin
            ebr = 32'(scl(xr * sx(iwr)) + scl(xi * sx(iwc)));
            ebc = 32'(scl(xi * sx(iwr)) - scl(xr * sx(iwc)));
        end else begin
            case (g)
                1:       begin cwr = 1;  cwi = 0;  end
                2:       begin cwr = -1; cwi = 0;  end
                3:       begin cwr = 0;  cwi = -1; end
                default: begin cwr = 0;  cwi = 1;  end
            endcase
            ebr = 32'(xr * cwr - xi * cwi);
            ebc = 32'(xr * cwi + xi * cwr);
        end
    endfunction

    task automatic run_op(input int g, input logic [31:0] icr, icc, idr, idc, iwr, iwc);
        logic [31:0] ear, eac, ebr, ebc;
        int lat;
        model(g, icr, icc, idr, idc, iwr, iwc, ear, eac, ebr, ebc);
        tcr = icr; tcc = icc; tdr = idr; tdc = idc; twr = iwr; twc = iwc;
        check("rdy_idle", 32'(rr[g]), 32'd1);
        rv[g] = 1'b1;
        @(posedge clk); #1;
        rv[g] = 1'b0;
        tcr = $urandom; tcc = $urandom; tdr = $urandom; tdc = $urandom;
        lat = 1;
        while (!sv[g] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), (g == 0) ? 32'd5 : 32'd1);
        check("ar", ar_o[g], ear);
        check("ac", ac_o[g], eac);
        check("br", br_o[g], ebr);
        check("bc", bc_o[g], ebc);
        sr[g] = 1'b1;
        @(posedge clk); #1;
        sr[g] = 1'b0;
        check("val_drop", 32'(sv[g]), 32'd0);
        check("rdy_back", 32'(rr[g]), 32'd1);
    endtask

    initial begin
        logic [31:0] ear, eac, ebr, ebc;
        reset = 1'b1; rv = '0; sr = '0;
        tcr = '0; tcc = '0; tdr = '0; tdc = '0; twr = '0; twc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_val", 32'(sv), 32'd0);
        check("rst_rdy", 32'(rr), 32'h1f);
        check("rst_ar", ar_o[0], 32'd0);
        check("rst_bc", bc_o[0], 32'd0);
        reset = 1'b0;

        // Scenario 1, general twiddle w = j
        run_op(0, 32'h00008000, 32'h00010000, 32'h00008000, 32'hFFFF0000, 32'h0, 32'h00010000);
        check("s1_ar", ar_o[0], 32'h00008000);
        check("s1_ac", ac_o[0], 32'h0);
        check("s1_br", br_o[0], 32'h00010000);
        check("s1_bc", bc_o[0], 32'h0);

        // Scenario 2, w = 1
        run_op(0, 32'h00030000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h0);
        check("s2_ar", ar_o[0], 32'h00020000);
        check("s2_br", br_o[0], 32'h00010000);
        check("s2_bc", bc_o[0], 32'h00010000);

        // Scenario 3, hard-wired w = j, twiddle inputs are garbage
        run_op(3, 32'h00008000, 32'h00010000, 32'h00008000, 32'hFFFF0000, 32'hDEADBEEF, 32'hDEADBEEF);
        check("s3_br", br_o[3], 32'h00010000);
        check("s3_bc", bc_o[3], 32'h0);

        // Backpressure: hold for 10 cycles, a second request is ignored
        model(0, 32'h00030000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h0,
              ear, eac, ebr, ebc);
        tcr = 32'h00030000; tcc = 32'h00010000; tdr = 32'h00010000; tdc = 32'hFFFF0000;
        twr = 32'h00010000; twc = 32'h0;
        rv[0] = 1'b1;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        for (int i = 0; i < 10; i++) begin
            check("bp_val", 32'(sv[0]), 32'd1);
            check("bp_rdy", 32'(rr[0]), 32'd0);
            check("bp_ar", ar_o[0], ear);
            check("bp_br", br_o[0], ebr);
            check("bp_bc", bc_o[0], ebc);
            if (i == 3) begin
                tcr = $urandom; tdr = $urandom; twc = $urandom;
                rv[0] = 1'b1;
            end
            @(posedge clk); #1;
            rv[0] = 1'b0;
        end
        sr[0] = 1'b1;
        @(posedge clk); #1;
        sr[0] = 1'b0;
        check("bp_drop", 32'(sv[0]), 32'd0);
        check("bp_rdy1", 32'(rr[0]), 32'd1);
        check("bp_keep", ar_o[0], ear);

        // Reset in the middle of the multiply sequence
        tcr = $urandom; tcc = $urandom; tdr = $urandom; tdc = $urandom; twr = $urandom; twc = $urandom;
        rv[0] = 1'b1;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mr_val", 32'(sv[0]), 32'd0);
        check("mr_rdy", 32'(rr[0]), 32'd1);
        check("mr_ar", ar_o[0], 32'd0);
        check("mr_ac", ac_o[0], 32'd0);
        check("mr_br", br_o[0], 32'd0);
        check("mr_bc", bc_o[0], 32'd0);
        run_op(0, 32'h00030000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h0);

        // Full-scale sums must not wrap
        run_op(1, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0);
        check("fs_ar", ar_o[1], 32'h7FFFFFFF);
        check("fs_ac", ac_o[1], 32'h80000000);
        check("fs_br", br_o[1], 32'h0);

        // Half-LSB handling on the halving step
        run_op(1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef BFLY_INV_ROUND_EN
        check("rnd_ar", ar_o[1], 32'h1);
`else
        check("rnd_ar", ar_o[1], 32'h0);
`endif

        // Every hard-wired twiddle once, then random operations on all modes
        for (int g = 1; g < 5; g++)
            run_op(g, 32'h00050000, 32'h00020000, 32'h00010000, 32'hFFFD0000, $urandom, $urandom);
        for (int i = 0; i < 30; i++)
            run_op(int'($urandom_range(0, 4)), $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
